// File: rtl/mac_array.sv
// N_CH parallel signed multiply-accumulate lanes sharing one input stream.
// Each lane sums S1_NUM beats and presents the full sum plus a shifted, saturated result.
module mac_array #(
  parameter  int DATA_WIDTH = 8,
  parameter  int S1_NUM     = 4,
  parameter  int N_CH       = 2,
  parameter  int SF         = 4,
  localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(S1_NUM),
  localparam int CNT_WIDTH  = $clog2(S1_NUM)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        inp,
  input  logic [N_CH*DATA_WIDTH-1:0]   weight,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_CH*ACC_WIDTH-1:0]    mac_out,
  output logic [N_CH*DATA_WIDTH-1:0]   q_out,
  output logic [CNT_WIDTH-1:0]         beat_cnt
);

  localparam int PW = 2*DATA_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0] Q_MAX = ACC_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] Q_MIN = -Q_MAX - ACC_WIDTH'(1);

  typedef enum logic {ST_ACCUM, ST_HOLD} state_t;

  state_t                        r_state, w_next;
  logic signed [ACC_WIDTH-1:0]   r_acc [N_CH];
  logic [CNT_WIDTH-1:0]          r_cnt;
  logic [N_CH*ACC_WIDTH-1:0]     r_mac;
  logic [N_CH*DATA_WIDTH-1:0]    r_q;

  logic                          w_in_ready, w_out_valid, w_acc, w_take, w_last;
  logic signed [PW-1:0]          w_prod  [N_CH];
  logic signed [ACC_WIDTH-1:0]   w_sum   [N_CH];
  logic signed [ACC_WIDTH-1:0]   w_shift [N_CH];
  logic signed [DATA_WIDTH-1:0]  w_q     [N_CH];

  // Ready is gated by reset directly so it reads 0 throughout the reset cycle.
  assign w_in_ready = (r_state == ST_ACCUM) && !reset;
  assign w_acc      = w_in_ready && in_valid && enable;
  assign w_take     = w_acc && !clear;
  assign w_last     = (r_cnt == CNT_WIDTH'(S1_NUM-1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_ACCUM;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_out_valid = 1'b0;
    case (r_state)
      ST_ACCUM: if (w_take && w_last) w_next = ST_HOLD;
      ST_HOLD: begin
        w_out_valid = 1'b1;
        if (out_ready) w_next = ST_ACCUM;
      end
      default: w_next = ST_ACCUM;
    endcase
  end

  always_comb begin
    w_prod  = '{default: '0};
    w_sum   = '{default: '0};
    w_shift = '{default: '0};
    w_q     = '{default: '0};
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_prod[k]  = PW'($signed(inp)) * PW'($signed(weight[k*DATA_WIDTH +: DATA_WIDTH]));
      w_sum[k]   = r_acc[k] + ACC_WIDTH'(w_prod[k]);
      w_shift[k] = w_sum[k] >>> SF;
      if (w_shift[k] > Q_MAX)      w_q[k] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (w_shift[k] < Q_MIN) w_q[k] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else                         w_q[k] = w_shift[k][DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '{default: '0};
      r_cnt <= '0;
      r_mac <= '0;
      r_q   <= '0;
    end else if (r_state == ST_ACCUM) begin
      if (clear) begin
        r_acc <= '{default: '0};
        r_cnt <= '0;
      end else if (w_acc) begin
        if (w_last) begin
          for (int unsigned k = 0; k < N_CH; k++) begin
            r_mac[k*ACC_WIDTH +: ACC_WIDTH]   <= w_sum[k];
            r_q[k*DATA_WIDTH +: DATA_WIDTH]   <= w_q[k];
            r_acc[k]                          <= '0;
          end
          r_cnt <= '0;
        end else begin
          for (int unsigned k = 0; k < N_CH; k++) r_acc[k] <= w_sum[k];
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign mac_out   = r_mac;
  assign q_out     = r_q;
  assign beat_cnt  = r_cnt;

endmodule

// File: tb/tb_mac_array.sv
// Directed bench for mac_array (N_CH=2, S1_NUM=4, SF=4, DATA_WIDTH=8).
module tb_mac_array;

  logic        clk = 1'b0;
  logic        reset, enable, clear, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  inp;
  logic [15:0] weight;
  logic [35:0] mac_out;
  logic [15:0] q_out;
  logic [1:0]  beat_cnt;

  int checks   = 0;
  int failures = 0;

  logic signed [17:0] m0, m1;
  logic signed [7:0]  q0, q1;
  assign m0 = mac_out[17:0];
  assign m1 = mac_out[35:18];
  assign q0 = q_out[7:0];
  assign q1 = q_out[15:8];

  mac_array #(.DATA_WIDTH(8), .S1_NUM(4), .N_CH(2), .SF(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .inp(inp), .weight(weight),
    .out_valid(out_valid), .out_ready(out_ready), .mac_out(mac_out),
    .q_out(q_out), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int a, input int b0, input int b1);
    inp      = a[7:0];
    weight   = {b1[7:0], b0[7:0]};
    in_valid = 1'b1;
  endtask

  task automatic chk_res(input string tag, input int e0, input int e1, input int eq0, input int eq1);
    chk({tag, "_mac0"}, m0, e0);
    chk({tag, "_mac1"}, m1, e1);
    chk({tag, "_q0"}, q0, eq0);
    chk({tag, "_q1"}, q1, eq1);
  endtask

  // Test-1 stimulus: inp=i, lane0 w=i, lane1 w=-i; leaves the DUT in HOLD.
  task automatic frame1(input string tag);
    for (int i = 1; i <= 4; i++) begin
      drive(i, i, -i);
      tick();
    end
    chk({tag, "_ov"}, out_valid, 1);
    chk_res(tag, 30, -30, 1, -2);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; clear = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; inp = '0; weight = '0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mac", mac_out, 0);
    chk("rst_q", q_out, 0);
    chk("rst_cnt", beat_cnt, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // 1: basic frame, out_valid for exactly one cycle
    for (int i = 1; i <= 4; i++) begin
      drive(i, i, -i);
      tick();
      if (i < 4) chk("t1_ov_early", out_valid, 0);
    end
    chk("t1_ov", out_valid, 1);
    chk("t1_ir_hold", in_ready, 0);
    chk_res("t1", 30, -30, 1, -2);
    in_valid = 1'b0;
    tick();
    chk("t1_ov_drop", out_valid, 0);
    chk("t1_ir_back", in_ready, 1);

    // 2: saturation
    for (int i = 0; i < 4; i++) begin
      drive(127, 127, -128);
      tick();
    end
    chk_res("t2", 64516, -65024, 127, -128);
    in_valid = 1'b0;
    tick();

    // 3: backpressure, junk presented while holding
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2, 3, 5);
      tick();
    end
    chk_res("t3", 24, 40, 1, 2);
    drive(9, 9, 9);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_ov_hold", out_valid, 1);
      chk("t3_ir_hold", in_ready, 0);
      chk("t3_mac0_hold", m0, 24);
      chk("t3_q1_hold", q1, 2);
      chk("t3_cnt_hold", beat_cnt, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t3_ov_drop", out_valid, 0);
    chk("t3_ir_back", in_ready, 1);
    frame1("t3_second");
    in_valid = 1'b0;
    tick();

    // 4: enable gating with junk beats
    for (int i = 1; i <= 2; i++) begin
      drive(i, i, -i);
      tick();
    end
    enable = 1'b0;
    drive(99, 77, 77);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t4_cnt_hold", beat_cnt, 2);
      chk("t4_ir", in_ready, 1);
    end
    enable = 1'b1;
    for (int i = 3; i <= 4; i++) begin
      drive(i, i, -i);
      tick();
    end
    chk("t4_ov", out_valid, 1);
    chk_res("t4", 30, -30, 1, -2);
    in_valid = 1'b0;
    tick();

    // 5a: clear with beat 3 presented
    for (int i = 1; i <= 2; i++) begin
      drive(i, i, -i);
      tick();
    end
    drive(3, 3, -3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_clr_cnt", beat_cnt, 0);
    chk("t5_clr_ov", out_valid, 0);
    frame1("t5_clr");
    in_valid = 1'b0;
    tick();

    // 5b: reset with beat 3 presented
    for (int i = 1; i <= 2; i++) begin
      drive(i, i, -i);
      tick();
      chk("t5_rst_ov_pre", out_valid, 0);
    end
    drive(3, 3, -3);
    reset = 1'b1;
    tick();
    chk("t5_rst_cnt", beat_cnt, 0);
    chk("t5_rst_ov", out_valid, 0);
    chk("t5_rst_ir", in_ready, 0);
    chk("t5_rst_mac", mac_out, 0);
    reset = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("t5_rst_ov_after", out_valid, 0);
    chk("t5_rst_ir_after", in_ready, 1);
    frame1("t5_rst");
    in_valid = 1'b0;
    tick();

    // 6: back-to-back frames with in_valid held high
    for (int i = 1; i <= 4; i++) begin
      drive(i, i, -i);
      tick();
      if (i < 4) chk("t6_ir_a", in_ready, 1);
    end
    chk("t6_ir_hold", in_ready, 0);
    chk_res("t6_a", 30, -30, 1, -2);
    drive(10, 5, -7);
    tick();
    chk("t6_ir_back", in_ready, 1);
    chk("t6_ov_drop", out_valid, 0);
    chk("t6_cnt_b0", beat_cnt, 0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i < 4) begin
        chk("t6_ir_b", in_ready, 1);
        chk("t6_cnt_b", beat_cnt, i);
      end
    end
    chk("t6_ov_b", out_valid, 1);
    chk_res("t6_b", 200, -280, 12, -18);
    in_valid = 1'b0;
    tick();
    chk("t6_ov_end", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_array.md
Name: mac_array

Overview:
- Parametrised multi-channel successor to the single-lane MAC_unit.
- N_CH independent signed multiply-accumulate lanes share one input vector stream. Each lane has its own weight stream.
- Each lane accumulates S1_NUM accepted beats, then presents the full-precision sum and a scaled, saturated DATA_WIDTH result that feeds Sigmoid_unit.
- Valid/ready handshakes on both sides replace the free-running rdy pulse.

Parameters:
DATA_WIDTH, 8, signed input/weight/quantised-output width
S1_NUM, 4, beats (products) accumulated per result; must be >= 2
N_CH, 2, number of parallel neuron lanes
SF, 4, fractional bits removed by arithmetic right shift in quantisation
ACC_WIDTH, 2*DATA_WIDTH+$clog2(S1_NUM), derived localparam; accumulator/mac_out width per lane

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
enable  in  1  global beat-accept gate; when 0 no beat is accepted
clear  in  1  synchronous abort of the current frame (accumulators and beat count to 0)
in_valid  in  1  inp/weight beat valid
in_ready  out  1  block can accept a beat
inp  in  DATA_WIDTH  signed input, broadcast to all lanes
weight  in  N_CH*DATA_WIDTH  signed weights; lane k uses bits [k*DATA_WIDTH +: DATA_WIDTH]
out_valid  out  1  results valid
out_ready  in  1  downstream accepts results
mac_out  out  N_CH*ACC_WIDTH  signed full-precision sums, lane k at [k*ACC_WIDTH +: ACC_WIDTH]
q_out  out  N_CH*DATA_WIDTH  signed saturate(sum >>> SF) per lane
beat_cnt  out  $clog2(S1_NUM)  beats accepted in the current frame (debug)

Behaviour:
- Single clock domain. Reset is synchronous and active-high. All state changes happen on the rising edge of clk.
- Reset values: in_ready=0 during reset and 1 on the first cycle after. out_valid=0, mac_out=0, q_out=0, beat_cnt=0, all accumulators 0. FSM enters ACCUM.
- Beat accepted ("acc") when in_valid & in_ready & enable.
- FSM states:
  - ACCUM: in_ready=1, out_valid=0. On acc, each lane adds sign-extended inp*weight_k to its accumulator and beat_cnt increments.
    - If acc occurs with beat_cnt==S1_NUM-1, the final sum (accumulator + last product) is loaded into mac_out/q_out. Accumulators and beat_cnt reset to 0. Next state is HOLD.
    - Latency: out_valid rises the cycle after the last beat is accepted.
  - HOLD: in_ready=0, out_valid=1. mac_out and q_out stay stable. out_valid & out_ready takes the FSM to ACCUM, and out_valid drops next cycle.
- No beats are accepted in HOLD (single output buffer, no overlap).
- enable=0 in ACCUM: no accumulation and beat_cnt holds. in_ready stays 1, but the beat is dropped (not consumed).
- clear in ACCUM: accumulators and beat_cnt go to 0. A beat presented the same cycle is discarded. clear wins over acc.
- clear in HOLD: has no effect. Results remain until handshaken.
- Arithmetic:
  - Each product is a full 2*DATA_WIDTH signed value.
  - The accumulator is ACC_WIDTH bits and cannot overflow for S1_NUM beats.
  - q_out = sum >>> SF (arithmetic, floor). It is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- reset mid-frame or in HOLD: immediate return to reset values. The partial frame is lost and no output is produced.
- Lanes are fully independent. There is no cross-lane carry or shared saturation.

Test Plan:
1. Basic frame (N_CH=2, S1_NUM=4, SF=4): inp=1,2,3,4; lane0 w=1,2,3,4; lane1 w=-1,-2,-3,-4, out_ready=1.
   - Expect out_valid one cycle after the 4th beat, for exactly 1 cycle.
   - Expect mac_out={-30,30} and q_out={-2,1}.
2. Saturation: inp=127 for all 4 beats; lane0 w=127, lane1 w=-128.
   - Expect mac_out0=64516, q_out0=127.
   - Expect mac_out1=-65024, q_out1=-128.
3. Backpressure: complete a frame with out_ready=0 for 5 cycles.
   - Expect out_valid=1, in_ready=0, and mac_out/q_out unchanged throughout.
   - Raise out_ready: out_valid=0 next cycle and in_ready=1.
   - A second frame then yields correct, independent sums.
4. Enable gating: drop enable for 2 cycles between beats 2 and 3 of the test-1 stimulus while presenting junk beats.
   - Expect beat_cnt to hold at 2 and junk beats to be ignored.
   - Expect the result to be identical to test 1.
5. Clear and reset mid-frame: assert clear with beat 3 presented.
   - Expect beat_cnt=0 next cycle; then the full test-1 frame yields 30/-30.
   - Repeat with reset: same recovery, and out_valid never asserted for the aborted frame.
6. Back-to-back frames with in_valid held high and out_ready=1.
   - Expect in_ready=0 only during the single HOLD cycle.
   - Expect no beat lost and correct results for both frames.
